// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux_rr_arbiter
// Description : Round-robin arbiter for a shared 4:1 bit multiplexer. Grants
//               one of four requesters at a time, drives the mux select and
//               registers the selected data bit. A hold limit forces rotation
//               under contention so no requester can starve the others.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_rr_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] data_in,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       data_out,
  output logic       data_valid,
  output logic       timeout
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

  // Registered state and its next-state values
  logic [0:0] state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] hold_q, hold_d;
  logic       timeout_q, timeout_d;
  logic       data_out_q;
  logic       data_valid_q;

  // Combinational helpers
  logic       busy_w;
  logic       win_found_w;
  logic [1:0] win_idx_w;
  logic [1:0] cand_w;
  logic       others_w;
  logic       at_limit_w;

  assign busy_w     = |gnt_q;
  // Any request other than the current owner's (gnt_q is one-hot in GRANT)
  assign others_w   = |(req & ~gnt_q);
  assign at_limit_w = (hold_q == HOLD_LIMIT);

  // Pick the first set request bit, searching upward from the rotation pointer
  always_comb begin
    win_found_w = 1'b0;
    win_idx_w   = ptr_q;
    cand_w      = ptr_q;
    for (int k = 0; k < 4; k++) begin
      cand_w = ptr_q + 2'(k);
      if (!win_found_w && req[cand_w]) begin
        win_found_w = 1'b1;
        win_idx_w   = cand_w;
      end
    end
  end

  // FSM next-state: grant from IDLE, release or preempt from GRANT
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        gnt_d = 4'b0000;
        if (win_found_w) begin
          state_d = ST_GRANT;
          gnt_d   = 4'b0001 << win_idx_w;
          sel_d   = win_idx_w;
          hold_d  = 8'd1;
        end
      end
      ST_GRANT: begin
        if (!req[sel_q]) begin
          // Owner released; release wins over a simultaneous preemption
          state_d = ST_IDLE;
          gnt_d   = 4'b0000;
          ptr_d   = sel_q + 2'd1;
          hold_d  = 8'd0;
        end else if (at_limit_w && others_w) begin
          // Hold limit reached with someone else waiting: force rotation
          state_d   = ST_IDLE;
          gnt_d     = 4'b0000;
          ptr_d     = sel_q + 2'd1;
          hold_d    = 8'd0;
          timeout_d = 1'b1;
        end else if (!at_limit_w) begin
          // Saturate so a sole requester can keep the grant indefinitely
          hold_d = hold_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  // Control state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      gnt_q     <= 4'b0000;
      sel_q     <= 2'd0;
      ptr_q     <= 2'd0;
      hold_q    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  // Mux datapath: register the owner's data bit, one cycle behind busy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out_q   <= 1'b0;
      data_valid_q <= 1'b0;
    end else begin
      data_out_q   <= busy_w ? data_in[sel_q] : 1'b0;
      data_valid_q <= busy_w;
    end
  end

  assign gnt        = gnt_q;
  assign sel        = sel_q;
  assign busy       = busy_w;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign timeout    = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_rr_arbiter
// Description : Directed self-checking bench for mux_rr_arbiter (MAX_HOLD=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] data_in;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       data_out;
  logic       data_valid;
  logic       timeout;

  int n_checks = 0;
  int n_fail   = 0;

  mux_rr_arbiter #(.MAX_HOLD(4)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .data_in    (data_in),
    .gnt        (gnt),
    .sel        (sel),
    .busy       (busy),
    .data_out   (data_out),
    .data_valid (data_valid),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Advance one rising edge and settle before sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " gnt"},        32'(gnt),        32'h0);
    check({tag, " sel"},        32'(sel),        32'h0);
    check({tag, " busy"},       32'(busy),       32'h0);
    check({tag, " data_out"},   32'(data_out),   32'h0);
    check({tag, " data_valid"}, 32'(data_valid), 32'h0);
    check({tag, " timeout"},    32'(timeout),    32'h0);
  endtask

  initial begin
    logic [1:0] order [5];
    order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd3; order[4] = 2'd0;

    // 1. Reset with everything asserted
    rst_n = 1'b0; req = 4'hF; data_in = 4'hF;
    step(); step();
    check_reset_outputs("reset");

    // 2. Single requester 2
    rst_n = 1'b1; req = 4'b0100; data_in = 4'b0100;
    step();                                   // edge 1
    check("single gnt",  32'(gnt),  32'h4);
    check("single sel",  32'(sel),  32'h2);
    check("single busy", 32'(busy), 32'h1);
    check("single dv_lag", 32'(data_valid), 32'h0);
    step();                                   // edge 2
    check("single dout",  32'(data_out),   32'h1);
    check("single dv",    32'(data_valid), 32'h1);
    data_in = 4'b1011;
    step();                                   // edge 3
    check("single dout0", 32'(data_out),   32'h0);
    check("single dv3",   32'(data_valid), 32'h1);
    step();                                   // edge 4
    req = 4'b0000;
    step();                                   // edge 5
    check("release gnt",  32'(gnt),        32'h0);
    check("release busy", 32'(busy),       32'h0);
    check("release dv5",  32'(data_valid), 32'h1);
    check("release sel",  32'(sel),        32'h2);
    step();                                   // edge 6
    check("release dv6",  32'(data_valid), 32'h0);
    check("release dout", 32'(data_out),   32'h0);

    // 4. Pointer wrap: pointer is 3 after owner 2 released
    req = 4'b1000;
    step();
    check("wrap gnt3", 32'(gnt), 32'h8);
    req = 4'b0101;
    step();
    check("wrap idle", 32'(gnt), 32'h0);
    check("wrap to",   32'(timeout), 32'h0);
    step();
    check("wrap gnt0", 32'(gnt), 32'h1);
    check("wrap sel0", 32'(sel), 32'h0);
    req = 4'b0000;
    step();

    // 3. Full contention after a reset (pointer back to 0)
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; req = 4'hF;
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        check($sformatf("rot g%0d c%0d gnt", g, c), 32'(gnt), 32'(4'b0001 << order[g]));
        check($sformatf("rot g%0d c%0d to", g, c), 32'(timeout), 32'h0);
        check($sformatf("rot g%0d c%0d onehot", g, c), 32'($onehot0(gnt)), 32'h1);
      end
      step();
      check($sformatf("rot g%0d idle gnt", g), 32'(gnt), 32'h0);
      check($sformatf("rot g%0d idle to", g), 32'(timeout), 32'h1);
    end

    // 5. Sole requester is never preempted (pointer is 1 here)
    req = 4'b0010;
    for (int c = 0; c < 20; c++) begin
      step();
      check($sformatf("sole c%0d gnt", c), 32'(gnt), 32'h2);
      check($sformatf("sole c%0d to", c), 32'(timeout), 32'h0);
    end
    req = 4'b0110;
    step();
    check("preempt gnt", 32'(gnt),     32'h0);
    check("preempt to",  32'(timeout), 32'h1);
    step();
    check("after gnt",  32'(gnt),     32'h4);
    check("after sel",  32'(sel),     32'h2);
    check("after to",   32'(timeout), 32'h0);

    // 6. Reset in the middle of an owner-2 grant
    step();
    rst_n = 1'b0;
    step();
    check_reset_outputs("midreset");
    rst_n = 1'b1; req = 4'b0101;
    step();
    check("midreset ptr gnt", 32'(gnt), 32'h1);
    check("midreset ptr sel", 32'(sel), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
